// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: MD op codes, the md instruction-type
// code used by decode and stall logic, and the FSM state type.
package md_unit_pkg;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MFHI  = 4'd4;
    localparam logic [3:0] MD_MFLO  = 4'd5;
    localparam logic [3:0] MD_MTHI  = 4'd6;
    localparam logic [3:0] MD_MTLO  = 4'd7;
    localparam logic [3:0] MD_MADD  = 4'd8;
    localparam logic [3:0] MD_MADDU = 4'd9;
    localparam logic [3:0] MD_MSUB  = 4'd10;
    localparam logic [3:0] MD_MSUBU = 4'd11;

    // Instruction-type code that CU and the stall unit use to tag md instructions.
    localparam logic [2:0] INSTR_TYPE_MD = 3'd5;

    localparam int CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; latency is modelled by a down-counter.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built only when MD_MADD_EN is defined.
//
// state   | meaning
// IDLE    | no operation in flight; accepts mult/div/mthi/mtlo
// BUSY    | counter running; HI/LO written on the edge where the counter is 1
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op;
    logic [31:0]      r_rs;
    logic [31:0]      r_rt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_long_op;
    logic             w_is_div;
    logic             w_launch;
    logic             w_done;
    logic             w_wr_en;
    logic [31:0]      w_hi_nxt;
    logic [31:0]      w_lo_nxt;

    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic [31:0]      w_rs_mag;
    logic [31:0]      w_rt_mag;
    logic [31:0]      w_dvs_safe;
    logic [31:0]      w_uq;
    logic [31:0]      w_ur;
    logic [31:0]      w_sq_mag;
    logic [31:0]      w_sr_mag;
    logic [31:0]      w_sq;
    logic [31:0]      w_sr;

    always_comb begin
        w_long_op = 1'b0;
        w_is_div  = 1'b0;
        case (md_op)
            MD_MULT, MD_MULTU: w_long_op = 1'b1;
            MD_DIV, MD_DIVU: begin
                w_long_op = 1'b1;
                w_is_div  = 1'b1;
            end
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: w_long_op = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_long_op) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_prod_s = {{32{r_rs[31]}}, r_rs} * {{32{r_rt[31]}}, r_rt};
    assign w_prod_u = {32'd0, r_rs} * {32'd0, r_rt};

    // Signed divide runs on magnitudes so 0x80000000 / -1 never overflows the divider.
    assign w_rs_mag   = r_rs[31] ? (32'd0 - r_rs) : r_rs;
    assign w_rt_mag   = r_rt[31] ? (32'd0 - r_rt) : r_rt;
    assign w_dvs_safe = (r_rt == 32'd0) ? 32'd1 : r_rt;
    assign w_uq       = r_rs / w_dvs_safe;
    assign w_ur       = r_rs % w_dvs_safe;
    assign w_sq_mag   = w_rs_mag / ((w_rt_mag == 32'd0) ? 32'd1 : w_rt_mag);
    assign w_sr_mag   = w_rs_mag % ((w_rt_mag == 32'd0) ? 32'd1 : w_rt_mag);
    assign w_sq       = (r_rs[31] ^ r_rt[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr       = r_rs[31] ? (32'd0 - w_sr_mag) : w_sr_mag;

    always_comb begin
        w_wr_en  = 1'b0;
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        case (r_op)
            MD_MULT: begin
                w_wr_en              = 1'b1;
                {w_hi_nxt, w_lo_nxt} = w_prod_s;
            end
            MD_MULTU: begin
                w_wr_en              = 1'b1;
                {w_hi_nxt, w_lo_nxt} = w_prod_u;
            end
            MD_DIV: begin
                w_wr_en  = (r_rt != 32'd0);
                w_hi_nxt = w_sr;
                w_lo_nxt = w_sq;
            end
            MD_DIVU: begin
                w_wr_en  = (r_rt != 32'd0);
                w_hi_nxt = w_ur;
                w_lo_nxt = w_uq;
            end
`ifdef MD_MADD_EN
            MD_MADD: begin
                w_wr_en              = 1'b1;
                {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + w_prod_s;
            end
            MD_MADDU: begin
                w_wr_en              = 1'b1;
                {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + w_prod_u;
            end
            MD_MSUB: begin
                w_wr_en              = 1'b1;
                {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} - w_prod_s;
            end
            MD_MSUBU: begin
                w_wr_en              = 1'b1;
                {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} - w_prod_u;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_rs  <= '0;
            r_rt  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_launch) begin
                r_op  <= md_op;
                r_rs  <= rs_val;
                r_rt  <= rt_val;
                r_cnt <= w_is_div ? DIV_LOAD : MULT_LOAD;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_done && w_wr_en) begin
                r_hi <= w_hi_nxt;
                r_lo <= w_lo_nxt;
            end else if (r_state == ST_IDLE && start) begin
                if (md_op == MD_MTHI) r_hi <= rs_val;
                if (md_op == MD_MTLO) r_lo <= rs_val;
            end
        end
    end

    assign busy    = (r_state == ST_BUSY);
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign rd_data = (md_op == MD_MFHI) ? r_hi :
                     (md_op == MD_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table and random ops feed a scoreboard that a
// busy-falling-edge monitor drains; hand sequences cover reset, MTHI/MFHI and violations.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'hF;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[8];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    int   busy_run = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            busy_run  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                busy_run++;
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_busy: busy ran %0d cycles with nothing expected", busy_run);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({e.name, "_cycles"}, 32'(busy_run), 32'(e.cycles));
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                end
                busy_run = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        @(posedge clk); #1;
        start  = 1'b0;
        md_op  = 4'hF;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results still pending, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic expect_op(input int cyc, input logic [31:0] h, input logic [31:0] l,
                             input string name);
        exp_t e;
        e.cycles = cyc;
        e.hi     = h;
        e.lo     = l;
        e.name   = name;
        sb_q.push_back(e);
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] u;
        e.name   = "rand";
        e.cycles = (op == MD_DIV || op == MD_DIVU) ? 10 : 5;
        e.hi     = '0;
        e.lo     = '0;
        case (op)
            MD_MULT: begin
                p    = longint'($signed(a)) * longint'($signed(b));
                u    = 64'(p);
                e.hi = u[63:32];
                e.lo = u[31:0];
            end
            MD_MULTU: begin
                u    = {32'd0, a} * {32'd0, b};
                e.hi = u[63:32];
                e.lo = u[31:0];
            end
            MD_DIV: begin
                q    = longint'($signed(a)) / longint'($signed(b));
                r    = longint'($signed(a)) % longint'($signed(b));
                e.lo = 32'(q);
                e.hi = 32'(r);
            end
            default: begin
                e.lo = a / b;
                e.hi = a % b;
            end
        endcase
        return e;
    endfunction

    initial begin
        logic        saw_busy;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        exp_t        re;

        tbl[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA, "mult"};
        tbl[1] = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA, "multu"};
        tbl[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg"};
        tbl[3] = '{MD_DIVU,  32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, "divu_by0"};
        tbl[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_ovf"};
        tbl[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, "div_negdvs"};
        tbl[6] = '{MD_DIVU,  32'hFFFFFFFF, 32'd16,       10, 32'h0000000F, 32'h0FFFFFFF, "divu_big"};
        tbl[7] = '{MD_DIV,   32'd0,        32'd0,        10, 32'h0000000F, 32'h0FFFFFFF, "div_by0"};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        for (int i = 0; i < 8; i++) begin
            expect_op(tbl[i].cycles, tbl[i].hi, tbl[i].lo, tbl[i].name);
            issue(tbl[i].op, tbl[i].rs, tbl[i].rt);
            wait_done();
        end

        for (int i = 0; i < 6; i++) begin
            rop = 4'(i % 4);
            ra  = $urandom;
            rb  = $urandom;
            if (rb == 32'd0) rb = 32'd1;
            re  = model(rop, ra, rb);
            sb_q.push_back(re);
            issue(rop, ra, rb);
            wait_done();
        end

        issue(MD_MTHI, 32'h00001234, 32'd0);
        md_op = MD_MFHI;
        @(negedge clk);
        check("mfhi_rd", rd_data, 32'h00001234);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(MD_MTLO, 32'h00005678, 32'd0);
        md_op = MD_MFLO;
        @(negedge clk);
        check("mflo_rd", rd_data, 32'h00005678);
        md_op = MD_MULT;
        @(negedge clk);
        check("rd_other", rd_data, 32'd0);

        expect_op(5, 32'd0, 32'd30, "mult_viol");
        issue(MD_MULT, 32'd5, 32'd6);
        start  = 1'b1;
        md_op  = MD_MTLO;
        rs_val = 32'hDEAD;
        @(posedge clk); #1;
        md_op  = MD_DIV;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(posedge clk); #1;
        start  = 1'b0;
        md_op  = 4'hF;
        wait_done();

        issue(MD_MTHI, 32'd0, 32'd0);
        issue(MD_MTLO, 32'hFFFFFFFF, 32'd0);
`ifdef MD_MADD_EN
        expect_op(5, 32'd1, 32'd0, "maddu");
        issue(MD_MADDU, 32'd1, 32'd1);
        wait_done();
`else
        issue(MD_MADDU, 32'd1, 32'd1);
        saw_busy = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("maddu_off_busy", 32'(saw_busy), 32'd0);
        check("maddu_off_hi", hi, 32'd0);
        check("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

        issue(MD_MTHI, 32'h0000AAAA, 32'd0);
        issue(MD_DIV, 32'd100, 32'd3);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_div_busy", 32'(busy), 32'd0);
        check("rst_div_hi", hi, 32'd0);
        check("rst_div_lo", lo, 32'd0);
        repeat (15) @(negedge clk);
        check("rst_late_hi", hi, 32'd0);
        check("rst_late_lo", lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
